dma_channel_scheduler: RTL and testbench
========================================

# dma_channel_scheduler

Shares a single DMA engine between NUM_CH requesting channels. Each channel presents a transfer descriptor (start address, length in units, direction mode); the scheduler arbitrates round-robin, hands the winning descriptor to the DMA engine's address/length interface, counts transferred units, and signals per-channel completion. It sits between the CPU-side descriptor registers and the DMA datapath with its ping-pong FIFOs, and is the only block that drives the DMA mode and address inputs.

## Interface
- NUM_CH, 4, number of requesting channels (2..8)
- ADDR_W, 32, address width
- LEN_W, 32, length width (units = DMA beats)
- TIMEOUT_CYCLES, 1024, stall limit; used only with DMA_SCHED_TIMEOUT_EN
- clk  in  1  clock
- resetn  in  1  reset resetn, synchronous, active-low; clock clk
- ch_valid  in  NUM_CH  channel i has a descriptor pending
- ch_enable  out  NUM_CH  one-hot accept pulse; descriptor of channel i captured this cycle
- ch_addr  in  NUM_CH*ADDR_W  packed start addresses, channel i at [i*ADDR_W +: ADDR_W]
- ch_len  in  NUM_CH*LEN_W  packed lengths
- ch_mode  in  NUM_CH  direction per channel (0 = mem->cpu, 1 = cpu->mem)
- ch_done  out  NUM_CH  one-cycle completion pulse
- ch_err  out  NUM_CH  one-cycle abort pulse (DMA_SCHED_TIMEOUT_EN only; else tied 0)
- cmd_valid  out  1  descriptor on cmd_* is valid
- cmd_enable  in  1  DMA accepts descriptor
- cmd_addr  out  ADDR_W  latched start address
- cmd_len  out  LEN_W  latched length
- dma_mode  out  1  latched direction, stable from accept to done
- dma_beat  in  1  DMA moved one unit this cycle
- busy  out  1  state != IDLE
- cur_ch  out  clog2(NUM_CH)  channel currently owning the DMA

## Operation
- States: IDLE, ISSUE, RUN, DONE (plus ABORT with macro).
- IDLE: if any ch_valid, winner = first set bit scanning from rr_ptr upward with wrap; assert ch_enable[winner] that cycle; latch addr/len/mode, cur_ch <= winner; rr_ptr <= (winner+1) mod NUM_CH. Next: ISSUE if len != 0, else DONE.
- ISSUE: cmd_valid = 1; on cmd_enable -> RUN, remaining <= cmd_len.
- RUN: each dma_beat decrements remaining; beat with remaining == 1 -> DONE. No underflow; remaining never wraps.
- DONE: ch_done[cur_ch] = 1 for one cycle -> IDLE.
- dma_beat outside RUN ignored. ch_valid changes outside IDLE ignored; a channel is re-arbitrated only after it is serviced.
- Reset mid-transfer: all state discarded, no done pulse emitted for the aborted transfer.

## Timing
- Reset values: ch_enable 0, ch_done 0, ch_err 0, cmd_valid 0, cmd_addr 0, cmd_len 0, dma_mode 0, busy 0, cur_ch 0, rr_ptr 0, state IDLE.
- Accept to cmd_valid: 1 cycle. cmd_valid held with constant cmd_* until cmd_enable sampled high.
- Zero length: accept, next cycle ch_done, following cycle IDLE (2 cycles, no cmd_valid).
- Last beat to ch_done: 1 cycle; ch_done to next ch_enable: earliest 1 cycle later (IDLE).
- Minimum per-transfer overhead: 3 cycles beyond beats (IDLE, ISSUE, DONE).
- cmd_enable and dma_beat in the same ISSUE cycle: beat ignored.

## Configuration
- DMA_SCHED_TIMEOUT_EN defined: stall counter cleared on every dma_beat and on entering RUN, incremented in RUN; reaching TIMEOUT_CYCLES -> ABORT: ch_err[cur_ch] = 1 for one cycle, no ch_done, -> IDLE. Counter also runs in ISSUE (cmd_enable never arriving aborts identically).
- Not defined: no counter, no ABORT state, ch_err constant 0; transfer waits indefinitely.

## Test plan
- Single channel: ch_valid[0], addr 0x1000, len 4, mode 1; cmd_enable next cycle, 4 beats -> cmd_addr 0x1000, cmd_len 4, dma_mode 1 throughout, ch_done[0] one cycle after 4th beat.
- Round-robin: ch_valid = 4'b1111 held, each len 1 -> grant order 0,1,2,3,0; rr_ptr wraps.
- Zero length: ch_valid[2], len 0 -> ch_enable[2], ch_done[2] next cycle, cmd_valid never high.
- Back-pressure: cmd_enable low 5 cycles -> cmd_valid and cmd_* stable 5 cycles; beats during ISSUE do not decrement.
- Reset mid-RUN after 2 of 8 beats -> all outputs reset values next cycle, no ch_done; new request grants channel 0 first.
- With DMA_SCHED_TIMEOUT_EN, TIMEOUT_CYCLES 16: no beats in RUN -> ch_err[cur_ch] after 16 cycles, ch_done stays 0, busy falls next cycle.

Source files
------------

// File: rtl/dma_channel_scheduler.sv
// Round-robin scheduler sharing one DMA engine between NUM_CH descriptor channels.
// Optional stall watchdog with abort: define DMA_SCHED_TIMEOUT_EN.
module dma_channel_scheduler #(
  parameter int NUM_CH         = 4,
  parameter int ADDR_W         = 32,
  parameter int LEN_W          = 32,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [NUM_CH-1:0]        ch_valid,
  output logic [NUM_CH-1:0]        ch_enable,
  input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
  input  logic [NUM_CH*LEN_W-1:0]  ch_len,
  input  logic [NUM_CH-1:0]        ch_mode,
  output logic [NUM_CH-1:0]        ch_done,
  output logic [NUM_CH-1:0]        ch_err,
  output logic                     cmd_valid,
  input  logic                     cmd_enable,
  output logic [ADDR_W-1:0]        cmd_addr,
  output logic [LEN_W-1:0]         cmd_len,
  output logic                     dma_mode,
  input  logic                     dma_beat,
  output logic                     busy,
  output logic [CH_W-1:0]          cur_ch
);

`ifdef DMA_SCHED_TIMEOUT_EN
  typedef enum logic [2:0] {IDLE, ISSUE, RUN, DONE, ABORT} state_t;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] stall_cnt;
  logic             stall_expired;
`else
  typedef enum logic [1:0] {IDLE, ISSUE, RUN, DONE} state_t;
`endif

  state_t            state, state_next;
  logic [CH_W-1:0]   rr_ptr;
  logic [LEN_W-1:0]  remaining;
  logic              grant_found;
  logic [CH_W-1:0]   grant_idx;
  logic [CH_W-1:0]   scan_idx;
  logic [ADDR_W-1:0] sel_addr;
  logic [LEN_W-1:0]  sel_len;
  logic              accept;
  logic              start_run;

  // First pending channel at or after rr_ptr, wrapping; then mux its descriptor.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    sel_addr    = '0;
    sel_len     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      scan_idx = CH_W'((int'(rr_ptr) + i) % NUM_CH);
      if (!grant_found && ch_valid[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant_idx == CH_W'(i)) begin
        sel_addr = ch_addr[i*ADDR_W +: ADDR_W];
        sel_len  = ch_len[i*LEN_W +: LEN_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    ch_enable  = '0;
    ch_done    = '0;
    ch_err     = '0;
    cmd_valid  = 1'b0;
    accept     = 1'b0;
    start_run  = 1'b0;
    case (state)
      IDLE: begin
        if (grant_found && resetn) begin
          accept               = 1'b1;
          ch_enable[grant_idx] = 1'b1;
          state_next           = (sel_len == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        cmd_valid = 1'b1;
        if (cmd_enable) begin
          start_run  = 1'b1;
          state_next = RUN;
        end
`ifdef DMA_SCHED_TIMEOUT_EN
        else if (stall_expired) state_next = ABORT;
`endif
      end
      RUN: begin
        // A beat always wins over a simultaneous stall expiry.
        if (dma_beat && remaining == LEN_W'(1)) state_next = DONE;
`ifdef DMA_SCHED_TIMEOUT_EN
        else if (!dma_beat && stall_expired) state_next = ABORT;
`endif
      end
      DONE: begin
        ch_done[cur_ch] = 1'b1;
        state_next      = IDLE;
      end
`ifdef DMA_SCHED_TIMEOUT_EN
      ABORT: begin
        ch_err[cur_ch] = 1'b1;
        state_next     = IDLE;
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cur_ch    <= '0;
      rr_ptr    <= '0;
      cmd_addr  <= '0;
      cmd_len   <= '0;
      dma_mode  <= 1'b0;
      remaining <= '0;
    end else begin
      if (accept) begin
        cmd_addr <= sel_addr;
        cmd_len  <= sel_len;
        dma_mode <= ch_mode[grant_idx];
        cur_ch   <= grant_idx;
        rr_ptr   <= (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
      end
      if (start_run)
        remaining <= cmd_len;
      else if (state == RUN && dma_beat && remaining != '0)
        remaining <= remaining - 1'b1;
    end
  end

`ifdef DMA_SCHED_TIMEOUT_EN
  assign stall_expired = (stall_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Watchdog counts cycles without progress while waiting on the DMA engine.
  always_ff @(posedge clk) begin
    if (!resetn)
      stall_cnt <= '0;
    else if (accept || start_run || (state == RUN && dma_beat))
      stall_cnt <= '0;
    else if (state == ISSUE || state == RUN)
      stall_cnt <= stall_cnt + 1'b1;
  end
`endif

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_dma_channel_scheduler.sv
// Directed scoreboard bench for dma_channel_scheduler; expected descriptors are
// queued when a request is driven and popped when the grant appears.
module tb_dma_channel_scheduler;
  localparam int NUM_CH = 4;
  localparam int ADDR_W = 32;
  localparam int LEN_W  = 32;
  localparam int CH_W   = 2;

  typedef struct {
    int          ch;
    logic [31:0] addr;
    logic [31:0] len;
    logic        mode;
  } txn_t;

  logic                     clk = 1'b0;
  logic                     resetn;
  logic [NUM_CH-1:0]        ch_valid;
  logic [NUM_CH-1:0]        ch_enable;
  logic [NUM_CH*ADDR_W-1:0] ch_addr;
  logic [NUM_CH*LEN_W-1:0]  ch_len;
  logic [NUM_CH-1:0]        ch_mode;
  logic [NUM_CH-1:0]        ch_done;
  logic [NUM_CH-1:0]        ch_err;
  logic                     cmd_valid;
  logic                     cmd_enable;
  logic [ADDR_W-1:0]        cmd_addr;
  logic [LEN_W-1:0]         cmd_len;
  logic                     dma_mode;
  logic                     dma_beat;
  logic                     busy;
  logic [CH_W-1:0]          cur_ch;

  int   checks   = 0;
  int   failures = 0;
  txn_t exp_q[$];
  logic [31:0] model_addr [NUM_CH];
  logic [31:0] model_len  [NUM_CH];
  logic        model_mode [NUM_CH];

  dma_channel_scheduler #(
    .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .resetn(resetn), .ch_valid(ch_valid), .ch_enable(ch_enable),
    .ch_addr(ch_addr), .ch_len(ch_len), .ch_mode(ch_mode), .ch_done(ch_done),
    .ch_err(ch_err), .cmd_valid(cmd_valid), .cmd_enable(cmd_enable),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .dma_mode(dma_mode),
    .dma_beat(dma_beat), .busy(busy), .cur_ch(cur_ch)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic setDesc(input int ch, input logic [31:0] addr, input logic [31:0] len, input logic mode);
    model_addr[ch] = addr;
    model_len[ch]  = len;
    model_mode[ch] = mode;
    ch_addr[ch*ADDR_W +: ADDR_W] = addr;
    ch_len[ch*LEN_W +: LEN_W]    = len;
    ch_mode[ch]                  = mode;
  endtask

  // Drives the request mask and queues the descriptor expected to win.
  task automatic applyStimulus(input logic [NUM_CH-1:0] mask, input int winner);
    txn_t t;
    t.ch   = winner;
    t.addr = model_addr[winner];
    t.len  = model_len[winner];
    t.mode = model_mode[winner];
    exp_q.push_back(t);
    ch_valid = mask;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_ch_enable"}, ch_enable, 0);
    checkOutput({tag, "_ch_done"},   ch_done,   0);
    checkOutput({tag, "_ch_err"},    ch_err,    0);
    checkOutput({tag, "_cmd_valid"}, cmd_valid, 0);
    checkOutput({tag, "_cmd_addr"},  cmd_addr,  0);
    checkOutput({tag, "_cmd_len"},   cmd_len,   0);
    checkOutput({tag, "_dma_mode"},  dma_mode,  0);
    checkOutput({tag, "_busy"},      busy,      0);
    checkOutput({tag, "_cur_ch"},    cur_ch,    0);
  endtask

  // Called in the IDLE cycle where the request is presented; returns in the following IDLE cycle.
  task automatic doTransfer(input int stall, input bit beat_in_issue, input bit hold_valid);
    txn_t t;
    logic [NUM_CH-1:0] onehot;
    #1;
    if (exp_q.size() == 0) begin
      checkOutput("scoreboard_underflow", 1, 0);
      return;
    end
    t = exp_q.pop_front();
    onehot = '0;
    onehot[t.ch] = 1'b1;
    checkOutput("grant", ch_enable, onehot);
    checkOutput("busy_idle", busy, 0);
    tick();
    if (!hold_valid) ch_valid = '0;
    if (t.len == 0) begin
      #1;
      checkOutput("zero_done", ch_done, onehot);
      checkOutput("zero_no_cmd", cmd_valid, 0);
      tick();
      #1;
      checkOutput("zero_idle", busy, 0);
      checkOutput("zero_no_cmd_after", cmd_valid, 0);
      return;
    end
    for (int s = 0; s < stall; s++) begin
      dma_beat = beat_in_issue;
      #1;
      checkOutput("issue_valid", cmd_valid, 1);
      checkOutput("issue_addr", cmd_addr, t.addr);
      checkOutput("issue_len", cmd_len, t.len);
      checkOutput("issue_mode", dma_mode, t.mode);
      tick();
    end
    cmd_enable = 1'b1;
    dma_beat   = beat_in_issue;
    #1;
    checkOutput("issue_valid_accept", cmd_valid, 1);
    checkOutput("issue_addr_accept", cmd_addr, t.addr);
    checkOutput("issue_len_accept", cmd_len, t.len);
    checkOutput("issue_cur_ch", cur_ch, t.ch);
    tick();
    cmd_enable = 1'b0;
    for (int b = 0; b < int'(t.len); b++) begin
      dma_beat = 1'b1;
      #1;
      checkOutput("run_no_done", ch_done, 0);
      checkOutput("run_mode", dma_mode, t.mode);
      checkOutput("run_no_cmd", cmd_valid, 0);
      tick();
    end
    dma_beat = 1'b0;
    #1;
    checkOutput("done_pulse", ch_done, onehot);
    checkOutput("done_no_err", ch_err, 0);
    checkOutput("done_busy", busy, 1);
    tick();
    #1;
    checkOutput("idle_after_done", busy, 0);
    checkOutput("done_single_cycle", ch_done, 0);
  endtask

  initial begin
    txn_t t;
    logic [NUM_CH-1:0] seen;
    resetn     = 1'b0;
    ch_valid   = '0;
    ch_addr    = '0;
    ch_len     = '0;
    ch_mode    = '0;
    cmd_enable = 1'b0;
    dma_beat   = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      model_addr[i] = '0;
      model_len[i]  = '0;
      model_mode[i] = 1'b0;
    end
    tick();
    tick();
    #1;
    checkResetValues("reset");
    resetn = 1'b1;
    tick();

    $display("[TB] round-robin with all channels requesting");
    for (int i = 0; i < NUM_CH; i++) setDesc(i, 32'h100 * (i + 1), 1, i[0]);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'b1111, i % NUM_CH);
      doTransfer(0, 1'b0, i < 4);
    end

    $display("[TB] single channel transfer");
    setDesc(0, 32'h1000, 4, 1'b1);
    applyStimulus(4'b0001, 0);
    doTransfer(0, 1'b0, 1'b0);

    $display("[TB] zero length");
    setDesc(2, 32'h3000, 0, 1'b0);
    applyStimulus(4'b0100, 2);
    doTransfer(0, 1'b0, 1'b0);

    $display("[TB] back-pressure with beats during issue");
    setDesc(1, 32'h2000, 3, 1'b0);
    applyStimulus(4'b0010, 1);
    doTransfer(5, 1'b1, 1'b0);

    $display("[TB] pointer skips to next pending channel");
    setDesc(3, 32'h4000, 2, 1'b1);
    applyStimulus(4'b1011, 3);
    doTransfer(0, 1'b0, 1'b0);

    $display("[TB] reset in the middle of a transfer");
    setDesc(2, 32'h5000, 8, 1'b1);
    applyStimulus(4'b0100, 2);
    #1;
    t = exp_q.pop_front();
    checkOutput("rst_grant", ch_enable, 4'b0100);
    tick();
    ch_valid   = '0;
    cmd_enable = 1'b1;
    tick();
    cmd_enable = 1'b0;
    dma_beat   = 1'b1;
    tick();
    tick();
    resetn = 1'b0;
    tick();
    #1;
    checkResetValues("midrun_reset");
    resetn   = 1'b1;
    dma_beat = 1'b0;
    seen     = '0;
    for (int i = 0; i < 8; i++) begin
      tick();
      seen |= ch_done;
    end
    checkOutput("no_done_after_reset", seen, 0);
    setDesc(0, 32'h6000, 1, 1'b0);
    applyStimulus(4'b1001, 0);
    doTransfer(0, 1'b0, 1'b0);

`ifdef DMA_SCHED_TIMEOUT_EN
    $display("[TB] stall timeout in run");
    setDesc(1, 32'h7000, 4, 1'b0);
    applyStimulus(4'b0010, 1);
    #1;
    t = exp_q.pop_front();
    checkOutput("to_grant", ch_enable, 4'b0010);
    tick();
    ch_valid   = '0;
    cmd_enable = 1'b1;
    tick();
    cmd_enable = 1'b0;
    seen       = '0;
    for (int i = 0; i < 16; i++) begin
      #1;
      seen |= ch_err;
      tick();
    end
    checkOutput("to_no_early_err", seen, 0);
    #1;
    checkOutput("to_err_pulse", ch_err, 4'b0010);
    checkOutput("to_no_done", ch_done, 0);
    tick();
    #1;
    checkOutput("to_idle", busy, 0);
    checkOutput("to_err_single", ch_err, 0);
`endif

    checkOutput("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
